// File: rtl/lfsr_pkg.sv
// Shared definitions for the Johnson-counter run controller.
// Holds the counter width, repetition width, Johnson period and controller state enum.
package lfsr_pkg;

  localparam int unsigned CNT_W          = 6;
  localparam int unsigned REP_W          = 8;
  localparam int unsigned JOHNSON_PERIOD = 2 * CNT_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } lfsr_ctrl_state_t;

endpackage

// File: rtl/lfsr_run_ctrl_if.sv
// Job and counter-control bundle for lfsr_run_ctrl.
// Job side:     start, abort, seed, target, reps -> ; <- busy, done, timeout, hits
// Counter side: tercnt -> ; <- cnt_data, cnt_count_to, cnt_load, cnt_cen
// slave is the controller view; master is the requester/counter view.
interface lfsr_run_ctrl_if #(
  parameter int unsigned CNT_W = lfsr_pkg::CNT_W,
  parameter int unsigned REP_W = lfsr_pkg::REP_W
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] seed;
  logic [CNT_W-1:0] target;
  logic [REP_W-1:0] reps;
  logic             tercnt;
  logic [CNT_W-1:0] cnt_data;
  logic [CNT_W-1:0] cnt_count_to;
  logic             cnt_load;
  logic             cnt_cen;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [REP_W-1:0] hits;

  modport master (
    output start, abort, seed, target, reps, tercnt,
    input  cnt_data, cnt_count_to, cnt_load, cnt_cen, busy, done, timeout, hits
  );

  modport slave (
    input  start, abort, seed, target, reps, tercnt,
    output cnt_data, cnt_count_to, cnt_load, cnt_cen, busy, done, timeout, hits
  );

endinterface

// File: rtl/lfsr_watchdog.sv
// Run-phase watchdog: counts enabled cycles, clr reloads zero (priority over en).
// Ports: clk, rst_n (async, active-low), clr, en, expired_c (count at TIMEOUT_CYC-1).
module lfsr_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] count_q;

  // Cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + TW'(1);
    end
  end

  assign expired_c = (count_q == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Job sequencer for a Johnson down-counter with terminal-count compare.
// Accepts (seed, target, reps) on start in IDLE, loads the counter, runs it and
// counts tercnt hits; pulses done after reps hits or timeout when a hit gap
// reaches TIMEOUT_CYC run cycles.
// Ports: clk, reset (async, active-low), bus (lfsr_run_ctrl_if.slave).
module lfsr_run_ctrl #(
  parameter int unsigned CNT_W       = lfsr_pkg::CNT_W,
  parameter int unsigned REP_W       = lfsr_pkg::REP_W,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            reset,
  lfsr_run_ctrl_if.slave  bus
);

  import lfsr_pkg::*;

  lfsr_ctrl_state_t state_q;
  lfsr_ctrl_state_t state_d;

  logic [CNT_W-1:0] seed_q;
  logic [CNT_W-1:0] target_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] hits_q;

  logic accept_c;
  logic hit_c;
  logic wd_clr_c;
  logic wd_en_c;
  logic wd_expired_c;

  logic busy_d, load_d, cen_d, done_d, timeout_d;
  logic busy_q, load_q, cen_q, done_q, timeout_q;

  // Timer runs only in RUN and restarts on every hit
  assign wd_en_c  = (state_q == RUN);
  assign wd_clr_c = (state_q != RUN) || bus.tercnt;

  lfsr_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expired_c (wd_expired_c)
  );

  // State and output registers; outputs are the Moore decode of the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      cen_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      cen_q     <= cen_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; abort overrides start, tercnt and timeout
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    hit_c    = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            accept_c = 1'b1;
            state_d  = (bus.reps == '0) ? DONE : LOAD;
          end
        end
        LOAD: state_d = RUN;
        RUN: begin
          if (bus.tercnt) begin
            hit_c = 1'b1;
            if ((hits_q + REP_W'(1)) == reps_q) begin
              state_d = DONE;
            end
          end else if (wd_expired_c) begin
            state_d = ERR;
          end
        end
        DONE:    state_d = IDLE;
        ERR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode of the next state (registered above)
  always_comb begin
    busy_d    = 1'b0;
    load_d    = 1'b0;
    cen_d     = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_d)
      LOAD: begin
        busy_d = 1'b1;
        load_d = 1'b1;
        cen_d  = 1'b1;  // counter clock is gated by cen, so load needs it
      end
      RUN: begin
        busy_d = 1'b1;
        cen_d  = 1'b1;
      end
      DONE:    done_d    = 1'b1;
      ERR:     timeout_d = 1'b1;
      default: ;
    endcase
  end

  // Job latches and hit counter; hits persists until the next accepted job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_q   <= '0;
      target_q <= '0;
      reps_q   <= '0;
      hits_q   <= '0;
    end else if (accept_c) begin
      seed_q   <= bus.seed;
      target_q <= bus.target;
      reps_q   <= bus.reps;
      hits_q   <= '0;
    end else if (hit_c) begin
      hits_q   <= hits_q + REP_W'(1);
    end
  end

  assign bus.cnt_data     = seed_q;
  assign bus.cnt_count_to = target_q;
  assign bus.cnt_load     = load_q;
  assign bus.cnt_cen      = cen_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.hits         = hits_q;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Bench for lfsr_run_ctrl: Johnson counter stand-in, job-level schedule model,
// per-cycle compare and directed jobs with hand-computed timings.
module tb_lfsr_run_ctrl;

  localparam int TMO = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t0  = 0;

  lfsr_run_ctrl_if bus ();

  lfsr_run_ctrl #(
    .CNT_W       (6),
    .REP_W       (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter stand-in: 6-bit Johnson sequence 000000,100000,110000,111000,...
  logic [5:0] jc;
  always @(posedge clk or negedge reset) begin
    if (!reset)           jc <= '0;
    else if (bus.cnt_cen) jc <= bus.cnt_load ? bus.cnt_data : {~jc[0], jc[5:1]};
  end
  assign bus.tercnt = (jc == bus.cnt_count_to);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: on acceptance, the whole schedule is precomputed.
  // r counts cycles since acceptance: r=1 load, r=2.. run, r=m_end_r done/err.
  bit         m_active = 1'b0;
  int         m_r = 0;
  int         m_end_r = 0;
  bit         m_end_done = 1'b0;
  int         m_hit_q[$];
  logic [5:0] m_seed = '0;
  logic [5:0] m_target = '0;
  logic [7:0] m_hits = '0;

  always @(posedge clk or negedge reset) begin
    logic [5:0] v;
    int gap;
    int h;
    if (!reset) begin
      m_active = 1'b0; m_seed = '0; m_target = '0; m_hits = '0;
      m_hit_q.delete();
    end else if (bus.abort) begin
      m_active = 1'b0;
      m_hit_q.delete();
    end else if (m_active) begin
      if (m_hit_q.size() > 0 && m_hit_q[0] == m_r) begin
        void'(m_hit_q.pop_front());
        m_hits = m_hits + 8'd1;
      end
      m_r++;
      if (m_r > m_end_r) m_active = 1'b0;
    end else if (bus.start) begin
      m_seed = bus.seed; m_target = bus.target; m_hits = '0;
      m_hit_q.delete();
      m_active = 1'b1; m_r = 1;
      if (bus.reps == 8'd0) begin
        m_end_r = 1; m_end_done = 1'b1;
      end else begin
        v = bus.seed; gap = 0; h = 0;
        for (int r = 2; r < 5000; r++) begin
          if (v == bus.target) begin
            h++; m_hit_q.push_back(r); gap = 0;
            if (h == int'(bus.reps)) begin m_end_r = r + 1; m_end_done = 1'b1; break; end
          end else begin
            gap++;
            if (gap == TMO) begin m_end_r = r + 1; m_end_done = 1'b0; break; end
          end
          v = {~v[0], v[5:1]};
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic e_busy, e_load, e_done, e_to;
    e_busy = m_active && (m_r < m_end_r);
    e_load = m_active && (m_r == 1) && (m_end_r > 1);
    e_done = m_active && (m_r == m_end_r) && m_end_done;
    e_to   = m_active && (m_r == m_end_r) && !m_end_done;
    chk("cmp_busy",     32'(bus.busy),         32'(e_busy));
    chk("cmp_load",     32'(bus.cnt_load),     32'(e_load));
    chk("cmp_cen",      32'(bus.cnt_cen),      32'(e_busy));
    chk("cmp_done",     32'(bus.done),         32'(e_done));
    chk("cmp_timeout",  32'(bus.timeout),      32'(e_to));
    chk("cmp_hits",     32'(bus.hits),         32'(m_hits));
    chk("cmp_data",     32'(bus.cnt_data),     32'(m_seed));
    chk("cmp_count_to", 32'(bus.cnt_count_to), 32'(m_target));
  end

  task automatic start_job(input logic [5:0] s, input logic [5:0] t, input logic [7:0] r);
    @(posedge clk); #1;
    bus.seed = s; bus.target = t; bus.reps = r; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  // Waits (bounded) for done/timeout, then checks hand-computed expectations
  task automatic wait_end(input string nm, input int exp_r, input bit exp_done,
                          input int exp_hits, input int exp_loads);
    int r = 0;
    int loads = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      r = cyc - t0 + 1;
      if (bus.cnt_load) loads++;
      if (bus.done || bus.timeout) seen = 1'b1;
    end
    chk({nm, "_seen"},    32'(seen), 32'd1);
    chk({nm, "_end_cyc"}, 32'(r), 32'(exp_r));
    chk({nm, "_done"},    32'(bus.done), 32'(exp_done));
    chk({nm, "_timeout"}, 32'(bus.timeout), 32'(!exp_done));
    chk({nm, "_hits"},    32'(bus.hits), 32'(exp_hits));
    chk({nm, "_loads"},   32'(loads), 32'(exp_loads));
    @(negedge clk);
    chk({nm, "_busy_after"},  32'(bus.busy), 32'd0);
    chk({nm, "_pulse_width"}, 32'(bus.done | bus.timeout), 32'd0);
    chk({nm, "_hits_hold"},   32'(bus.hits), 32'(exp_hits));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    int pulses;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.seed = '0; bus.target = '0; bus.reps = '0;

    // Reset state
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cen",  32'(bus.cnt_cen), 32'd0);
    chk("rst_hits", 32'(bus.hits), 32'd0);
    chk("rst_data", 32'(bus.cnt_data), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Single hit: hit on run cycle 4 (r=5), done at r=6
    start_job(6'b000000, 6'b111000, 8'd1);
    wait_end("single", 6, 1'b1, 1, 1);

    // Three hits on run cycles 4, 16, 28 -> done at r=30
    start_job(6'b000000, 6'b111000, 8'd3);
    wait_end("multi", 30, 1'b1, 3, 1);

    // Unreachable target: 64 run cycles, error at r=66
    start_job(6'b000000, 6'b101010, 8'd1);
    wait_end("unreach", 66, 1'b0, 0, 1);

    // reps=0: done straight after acceptance, no load
    start_job(6'd3, 6'd9, 8'd0);
    wait_end("reps0", 1, 1'b1, 0, 0);

    // seed==target: hit on run cycle 1, done at r=3
    start_job(6'b011111, 6'b011111, 8'd1);
    wait_end("eq", 3, 1'b1, 1, 1);

    // start during the DONE cycle is ignored
    start_job(6'b000000, 6'b111000, 8'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("donestart_done", 32'(bus.done), 32'd1);
    bus.seed = 6'h05; bus.target = 6'h07; bus.reps = 8'd2; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.cnt_load || bus.busy) pulses++;
    end
    chk("donestart_ignored", 32'(pulses), 32'd0);
    chk("donestart_latch", 32'(bus.cnt_count_to), 32'b111000);

    // Abort in run cycle 5 of a reps=3 job: one hit already counted
    start_job(6'b000000, 6'b111000, 8'd3);
    repeat (5) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_cen",  32'(bus.cnt_cen), 32'd0);
    chk("abort_hits", 32'(bus.hits), 32'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.timeout) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);

    // start with new job fields during RUN is ignored
    start_job(6'b000000, 6'b111000, 8'd3);
    repeat (3) @(posedge clk);
    #1 bus.seed = 6'h15; bus.target = 6'h2a; bus.reps = 8'd9; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_end("midstart", 30, 1'b1, 3, 0);
    chk("midstart_data",  32'(bus.cnt_data), 32'd0);
    chk("midstart_count", 32'(bus.cnt_count_to), 32'b111000);

    // Async reset between edges mid-run
    start_job(6'b000000, 6'b111000, 8'd3);
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_cen",   32'(bus.cnt_cen), 32'd0);
    chk("arst_load",  32'(bus.cnt_load), 32'd0);
    chk("arst_hits",  32'(bus.hits), 32'd0);
    chk("arst_data",  32'(bus.cnt_data), 32'd0);
    chk("arst_count", 32'(bus.cnt_count_to), 32'd0);
    chk("arst_pulse", 32'(bus.done | bus.timeout), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    start_job(6'b000000, 6'b111000, 8'd1);
    wait_end("post_rst", 6, 1'b1, 1, 1);

    #20;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_run_ctrl.md
Name: lfsr_run_ctrl

Overview:
- Sequencer directly upstream of the 6-bit twisted-ring (Johnson) down-counter with terminal-count compare.
- Takes a job (seed, target, repetition count) over a start/busy handshake, then drives the counter's data/count_to/load/cen inputs.
- Consumes the counter's tercnt and counts terminal hits.
- Reports done after the requested number of hits, or timeout if the target is never reached (a non-Johnson target code is unreachable).

Parameters:
- CNT_W, 6, counter width; must match the counter.
- REP_W, 8, width of the repetition count and hit counter.
- TIMEOUT_CYC, 64, max RUN cycles allowed between hits; must exceed the counter period (2*CNT_W = 12).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- seed  in  CNT_W  value loaded into the counter.
- target  in  CNT_W  terminal value for the counter.
- reps  in  REP_W  number of terminal hits required.
- tercnt  in  1  terminal-count flag from the counter.
- cnt_data  out  CNT_W  to the counter's data input.
- cnt_count_to  out  CNT_W  to the counter's count_to input.
- cnt_load  out  1  to the counter's load input.
- cnt_cen  out  1  to the counter's cen input.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse: job completed.
- timeout  out  1  one-cycle pulse: job failed.
- hits  out  REP_W  hits seen in the current or last job.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - seed, target and reps latches = 0.
  - hits=0, timer=0.
  - All outputs 0.
- States are IDLE, LOAD, RUN, DONE and ERR. Outputs are Moore decodes of registered state and latches.
- IDLE:
  - busy=0, cnt_cen=0, cnt_load=0.
  - On start=1, latch seed, target and reps; clear hits and timer.
  - If reps=0, go to DONE (no counter activity). Otherwise go to LOAD.
- LOAD (exactly 1 cycle):
  - busy=1, cnt_load=1.
  - cnt_cen=1, because the counter clock is gated by cen, so a load needs cen.
  - Go to RUN. From the next cycle the counter holds seed.
- RUN:
  - busy=1, cnt_cen=1, cnt_load=0.
  - Sample tercnt every cycle.
  - If tercnt=1: hits+=1 and timer=0. If the new hits equals reps, go to DONE.
  - If tercnt=0: timer+=1. When timer reaches TIMEOUT_CYC-1 with no hit, go to ERR.
- DONE (1 cycle): done=1, busy=0, cnt_cen=0 (counter frozen); go to IDLE.
- ERR (1 cycle): timeout=1, busy=0, cnt_cen=0; go to IDLE.
- cnt_data and cnt_count_to always drive the latched seed and target, including in IDLE.
- hits holds its value after the job ends until the next accepted start.
- start while busy (LOAD/RUN): ignored; latches are unchanged.
- start in the DONE/ERR cycle: ignored. The earliest accepted start is the following IDLE cycle.
- abort=1: go to IDLE next cycle with no done or timeout pulse; hits is retained. abort has priority over start, tercnt and timeout.
- seed==target: the first RUN cycle sees tercnt=1 and counts it as a hit.
- Width rules:
  - hits saturates at reps; it never wraps because the job ends at reps.
  - The timer is $clog2(TIMEOUT_CYC) bits.
- Reset mid-RUN: counter control drops immediately (cnt_cen=0); no done or timeout pulse.

Decomposition:
- Shared package lfsr_pkg:
  - CNT_W constant.
  - State enum lfsr_ctrl_state_t {IDLE, LOAD, RUN, DONE, ERR}.
  - Johnson period constant JOHNSON_PERIOD = 2*CNT_W.
- One sub-module, lfsr_watchdog: a loadable timer with clear, enable and expire outputs; parameterised by TIMEOUT_CYC.
- The FSM and hit counter stay in the top-level module.

Test Plan:
- Single hit: seed=6'b000000, target=6'b111000, reps=1.
  - Required: cnt_load=1 for one cycle.
  - tercnt hit on the 4th RUN cycle; done pulses on the next cycle; hits=1; busy low after done.
- Multiple hits: seed=000000, target=111000, reps=3.
  - Required: hits on RUN cycles 4, 16 and 28; done on the cycle after the 28th; hits=3.
- Unreachable target: target=6'b101010, seed=000000, reps=1.
  - Required: after 64 RUN cycles, timeout pulses once; done never asserts; hits=0.
- Edge cases:
  - reps=0 -> done on the 2nd cycle after start, cnt_load never asserts.
  - seed==target=6'b011111, reps=1 -> hit on RUN cycle 1.
- Abort and mid-job start:
  - abort asserted in RUN cycle 5 of a reps=3 job -> IDLE next cycle, no pulses, cnt_cen=0.
  - start with new seed/target pulsed during RUN -> latches unchanged.
- Async reset: reset=0 mid-RUN, asserted between clock edges.
  - Required: all outputs go to 0 immediately.
  - After release, a start is accepted normally.
